// File: rtl/exception_pkg.sv
// Shared exception definitions: ExcCode values, exception vector constants
// and the redirect controller state encoding.
package exception_pkg;

    // Sequencer states for exc_redirect_ctrl.
    typedef enum logic [1:0] {
        StIdle,
        StDrain,
        StCommit,
        StRedirect
    } exc_ctrl_state_t;

    // Exception vector bases and offsets.
    localparam logic [31:0] VEC_BASE_BEV1   = 32'hBFC0_0200;
    localparam logic [31:0] VEC_BASE_BEV0   = 32'h8000_0000;
    localparam logic [31:0] VEC_OFS_REFILL  = 32'h0000_0000;
    localparam logic [31:0] VEC_OFS_GENERAL = 32'h0000_0180;

    // Cause.ExcCode values.
    localparam logic [4:0] CODE_INT  = 5'd0;
    localparam logic [4:0] CODE_MOD  = 5'd1;
    localparam logic [4:0] CODE_TLBL = 5'd2;
    localparam logic [4:0] CODE_TLBS = 5'd3;
    localparam logic [4:0] CODE_ADEL = 5'd4;
    localparam logic [4:0] CODE_ADES = 5'd5;
    localparam logic [4:0] CODE_IBE  = 5'd6;
    localparam logic [4:0] CODE_DBE  = 5'd7;
    localparam logic [4:0] CODE_SYS  = 5'd8;
    localparam logic [4:0] CODE_BP   = 5'd9;
    localparam logic [4:0] CODE_RI   = 5'd10;
    localparam logic [4:0] CODE_CPU  = 5'd11;
    localparam logic [4:0] CODE_OV   = 5'd12;
    localparam logic [4:0] CODE_TR   = 5'd13;

    // Address-related exceptions are the only ones that update BadVAddr.
    function automatic logic code_has_badvaddr(input logic [4:0] code);
        return (code == CODE_MOD)  || (code == CODE_TLBL) || (code == CODE_TLBS) ||
               (code == CODE_ADEL) || (code == CODE_ADES);
    endfunction

endpackage

// File: rtl/exc_vector_gen.sv
// Exception vector generator: (BEV, refill, EXL) -> exception entry PC.
// The TLB refill vector is only available when EXC_TLB_REFILL_EN is defined;
// otherwise every exception enters at the general vector.
module exc_vector_gen
    import exception_pkg::*;
(
    input  logic        bev,
    input  logic        refill,
    input  logic        exl,
    output logic [31:0] vector_pc
);

    logic [31:0] base;
    logic [31:0] offset;

`ifdef EXC_TLB_REFILL_EN
    // Refill entry only applies when not already at exception level.
    always_comb begin
        offset = VEC_OFS_GENERAL;
        if (refill && !exl) begin
            offset = VEC_OFS_REFILL;
        end
    end
`else
    logic unused_refill_exl;
    assign unused_refill_exl = refill ^ exl;

    // Refill is not supported: everything goes to the general entry.
    always_comb begin
        offset = VEC_OFS_GENERAL;
    end
`endif

    assign base      = bev ? VEC_BASE_BEV1 : VEC_BASE_BEV0;
    assign vector_pc = base + offset;

endmodule

// File: rtl/exc_redirect_ctrl.sv
// Exception / ERET redirect sequencer. Captures one commit-stage event,
// flushes, waits for the memory system to drain, issues one CP0 update and
// then holds a PC redirect until fetch accepts it.
// Optional feature: EXC_TLB_REFILL_EN (TLB refill vector, see exc_vector_gen).
module exc_redirect_ctrl
    import exception_pkg::*;
#(
    parameter bit RESET_VECTOR_BEV = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        exc_valid,
    input  logic        exc_refill,
    input  logic [4:0]  exc_code,
    input  logic [31:0] exc_pc,
    input  logic        exc_in_delay_slot,
    input  logic [31:0] exc_badvaddr,
    input  logic        eret_valid,
    input  logic [31:0] cp0_epc,
    input  logic        cp0_status_bev,
    input  logic        cp0_status_exl,
    input  logic        mem_busy,
    input  logic        redirect_ready,
    output logic        flush,
    output logic        busy,
    output logic        cp0_we,
    output logic        cp0_exl_set,
    output logic        cp0_exl_clr,
    output logic        cp0_epc_we,
    output logic [31:0] cp0_epc_wdata,
    output logic        cp0_bd,
    output logic        cp0_code_we,
    output logic [4:0]  cp0_code,
    output logic        cp0_badvaddr_we,
    output logic [31:0] cp0_badvaddr,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc
);

    exc_ctrl_state_t state_q, state_d;

    logic        capture;
    logic        is_exc_q;
    logic        refill_q;
    logic [4:0]  code_q;
    logic [31:0] exc_epc_q;     // EPC to write, already adjusted for delay slot
    logic        bd_q;
    logic [31:0] badvaddr_q;
    logic [31:0] eret_pc_q;     // EPC sampled with an ERET
    logic        bev_q;
    logic        exl_q;
    logic [31:0] vector_pc;

    assign capture = (state_q == StIdle) && (exc_valid || eret_valid);

    // State register and event capture; payload is frozen for the whole sequence.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            is_exc_q   <= 1'b0;
            refill_q   <= 1'b0;
            code_q     <= 5'd0;
            exc_epc_q  <= 32'd0;
            bd_q       <= 1'b0;
            badvaddr_q <= 32'd0;
            eret_pc_q  <= 32'd0;
            // Only observable after a capture overwrites it; outputs stay gated.
            bev_q      <= RESET_VECTOR_BEV;
            exl_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            if (capture) begin
                is_exc_q   <= exc_valid;
                refill_q   <= exc_refill;
                code_q     <= exc_code;
                exc_epc_q  <= exc_in_delay_slot ? (exc_pc - 32'd4) : exc_pc;
                bd_q       <= exc_in_delay_slot;
                badvaddr_q <= exc_badvaddr;
                eret_pc_q  <= cp0_epc;
                bev_q      <= cp0_status_bev;
                exl_q      <= cp0_status_exl;
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:     if (exc_valid || eret_valid) state_d = StDrain;
            StDrain:    if (!mem_busy) state_d = StCommit;
            StCommit:   state_d = StRedirect;
            StRedirect: if (redirect_ready) state_d = StIdle;
            default:    state_d = StIdle;
        endcase
    end

    exc_vector_gen u_vector_gen (
        .bev       (bev_q),
        .refill    (refill_q),
        .exl       (exl_q),
        .vector_pc (vector_pc)
    );

    // Outputs decoded from state and captured payload only.
    always_comb begin
        flush           = 1'b0;
        busy            = (state_q != StIdle);
        cp0_we          = 1'b0;
        cp0_exl_set     = 1'b0;
        cp0_exl_clr     = 1'b0;
        cp0_epc_we      = 1'b0;
        cp0_epc_wdata   = 32'd0;
        cp0_bd          = 1'b0;
        cp0_code_we     = 1'b0;
        cp0_code        = 5'd0;
        cp0_badvaddr_we = 1'b0;
        cp0_badvaddr    = 32'd0;
        redirect_valid  = 1'b0;
        redirect_pc     = 32'd0;
        unique case (state_q)
            StDrain: begin
                flush = 1'b1;
            end
            StCommit: begin
                flush  = 1'b1;
                cp0_we = 1'b1;
                if (is_exc_q) begin
                    cp0_exl_set     = 1'b1;
                    // Nested exceptions keep the original EPC/BD.
                    cp0_epc_we      = !exl_q;
                    cp0_epc_wdata   = exc_epc_q;
                    cp0_bd          = bd_q;
                    cp0_code_we     = 1'b1;
                    cp0_code        = code_q;
                    cp0_badvaddr_we = code_has_badvaddr(code_q);
                    cp0_badvaddr    = badvaddr_q;
                end else begin
                    cp0_exl_clr = 1'b1;
                end
            end
            StRedirect: begin
                redirect_valid = 1'b1;
                redirect_pc    = is_exc_q ? vector_pc : eret_pc_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_exc_redirect_ctrl.sv
// Directed self-checking bench for exc_redirect_ctrl.
module tb_exc_redirect_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        exc_valid;
    logic        exc_refill;
    logic [4:0]  exc_code;
    logic [31:0] exc_pc;
    logic        exc_in_delay_slot;
    logic [31:0] exc_badvaddr;
    logic        eret_valid;
    logic [31:0] cp0_epc;
    logic        cp0_status_bev;
    logic        cp0_status_exl;
    logic        mem_busy;
    logic        redirect_ready;
    logic        flush;
    logic        busy;
    logic        cp0_we;
    logic        cp0_exl_set;
    logic        cp0_exl_clr;
    logic        cp0_epc_we;
    logic [31:0] cp0_epc_wdata;
    logic        cp0_bd;
    logic        cp0_code_we;
    logic [4:0]  cp0_code;
    logic        cp0_badvaddr_we;
    logic [31:0] cp0_badvaddr;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    int checks = 0;
    int failures = 0;

    exc_redirect_ctrl dut (
        .clk               (clk),
        .reset             (reset),
        .exc_valid         (exc_valid),
        .exc_refill        (exc_refill),
        .exc_code          (exc_code),
        .exc_pc            (exc_pc),
        .exc_in_delay_slot (exc_in_delay_slot),
        .exc_badvaddr      (exc_badvaddr),
        .eret_valid        (eret_valid),
        .cp0_epc           (cp0_epc),
        .cp0_status_bev    (cp0_status_bev),
        .cp0_status_exl    (cp0_status_exl),
        .mem_busy          (mem_busy),
        .redirect_ready    (redirect_ready),
        .flush             (flush),
        .busy              (busy),
        .cp0_we            (cp0_we),
        .cp0_exl_set       (cp0_exl_set),
        .cp0_exl_clr       (cp0_exl_clr),
        .cp0_epc_we        (cp0_epc_we),
        .cp0_epc_wdata     (cp0_epc_wdata),
        .cp0_bd            (cp0_bd),
        .cp0_code_we       (cp0_code_we),
        .cp0_code          (cp0_code),
        .cp0_badvaddr_we   (cp0_badvaddr_we),
        .cp0_badvaddr      (cp0_badvaddr),
        .redirect_valid    (redirect_valid),
        .redirect_pc       (redirect_pc)
    );

    always #5 clk = ~clk;

    // Advance one clock and sample 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        exc_valid         = 1'b0;
        exc_refill        = 1'b0;
        exc_code          = 5'd0;
        exc_pc            = 32'd0;
        exc_in_delay_slot = 1'b0;
        exc_badvaddr      = 32'd0;
        eret_valid        = 1'b0;
        cp0_epc           = 32'd0;
        cp0_status_bev    = 1'b0;
        cp0_status_exl    = 1'b0;
        mem_busy          = 1'b0;
        redirect_ready    = 1'b1;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1'b1;
        tick();
        tick();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", busy); end
        checks++; if (flush !== 1'b0) begin failures++; $display("FAIL reset_flush got=%0b exp=0", flush); end
        checks++; if (cp0_we !== 1'b0) begin failures++; $display("FAIL reset_cp0_we got=%0b exp=0", cp0_we); end
        checks++; if (redirect_valid !== 1'b0) begin failures++; $display("FAIL reset_redirect_valid got=%0b exp=0", redirect_valid); end
        checks++; if (redirect_pc !== 32'd0) begin failures++; $display("FAIL reset_redirect_pc got=%h exp=0", redirect_pc); end
        checks++; if ({cp0_epc_wdata, cp0_badvaddr, cp0_code, cp0_bd} !== 70'd0) begin
            failures++; $display("FAIL reset_data got=%h/%h/%0d/%0b exp=0", cp0_epc_wdata, cp0_badvaddr, cp0_code, cp0_bd);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_adel();
        clear_inputs();
        exc_valid = 1'b1; exc_code = 5'd4; exc_pc = 32'h8000_1000; exc_badvaddr = 32'h8000_1003;
        tick();  // cycle 1: DRAIN
        clear_inputs();
        checks++; if (busy !== 1'b1 || flush !== 1'b1 || cp0_we !== 1'b0) begin
            failures++; $display("FAIL adel_drain busy/flush/we got=%0b%0b%0b exp=110", busy, flush, cp0_we);
        end
        tick();  // cycle 2: COMMIT
        checks++; if (cp0_we !== 1'b1 || cp0_exl_set !== 1'b1 || cp0_exl_clr !== 1'b0) begin
            failures++; $display("FAIL adel_commit we/set/clr got=%0b%0b%0b exp=110", cp0_we, cp0_exl_set, cp0_exl_clr);
        end
        checks++; if (cp0_epc_we !== 1'b1 || cp0_epc_wdata !== 32'h8000_1000 || cp0_bd !== 1'b0) begin
            failures++; $display("FAIL adel_epc we=%0b epc=%h bd=%0b exp 1/80001000/0", cp0_epc_we, cp0_epc_wdata, cp0_bd);
        end
        checks++; if (cp0_code_we !== 1'b1 || cp0_code !== 5'd4) begin
            failures++; $display("FAIL adel_code we=%0b code=%0d exp 1/4", cp0_code_we, cp0_code);
        end
        checks++; if (cp0_badvaddr_we !== 1'b1 || cp0_badvaddr !== 32'h8000_1003) begin
            failures++; $display("FAIL adel_badvaddr we=%0b val=%h exp 1/80001003", cp0_badvaddr_we, cp0_badvaddr);
        end
        tick();  // cycle 3: REDIRECT
        checks++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h8000_0180) begin
            failures++; $display("FAIL adel_redirect valid=%0b pc=%h exp 1/80000180", redirect_valid, redirect_pc);
        end
        checks++; if (cp0_we !== 1'b0 || flush !== 1'b0) begin
            failures++; $display("FAIL adel_redirect_we_flush got=%0b%0b exp=00", cp0_we, flush);
        end
        tick();  // cycle 4: IDLE
        checks++; if (busy !== 1'b0 || redirect_valid !== 1'b0) begin
            failures++; $display("FAIL adel_idle busy=%0b rv=%0b exp 0/0", busy, redirect_valid);
        end
    endtask

    task automatic test_sys_delay_slot();
        clear_inputs();
        exc_valid = 1'b1; exc_code = 5'd8; exc_pc = 32'h8000_2004; exc_in_delay_slot = 1'b1;
        exc_badvaddr = 32'hDEAD_BEEF; cp0_status_exl = 1'b1;
        tick();
        clear_inputs();
        tick();  // COMMIT
        checks++; if (cp0_we !== 1'b1 || cp0_epc_we !== 1'b0) begin
            failures++; $display("FAIL sys_epc_we we=%0b epc_we=%0b exp 1/0", cp0_we, cp0_epc_we);
        end
        checks++; if (cp0_code !== 5'd8 || cp0_code_we !== 1'b1 || cp0_badvaddr_we !== 1'b0) begin
            failures++; $display("FAIL sys_code code=%0d code_we=%0b bv_we=%0b exp 8/1/0", cp0_code, cp0_code_we, cp0_badvaddr_we);
        end
        tick();
        checks++; if (redirect_pc !== 32'h8000_0180) begin
            failures++; $display("FAIL sys_redirect_pc got=%h exp=80000180", redirect_pc);
        end
        tick();
    endtask

    task automatic test_eret_drain();
        int we_pulses;
        we_pulses = 0;
        clear_inputs();
        eret_valid = 1'b1; cp0_epc = 32'h8000_3000; mem_busy = 1'b1;
        tick();  // DRAIN 1
        eret_valid = 1'b0; cp0_epc = 32'h0;
        for (int i = 0; i < 3; i++) begin
            checks++; if (flush !== 1'b1 || cp0_we !== 1'b0) begin
                failures++; $display("FAIL eret_drain%0d flush=%0b we=%0b exp 1/0", i, flush, cp0_we);
            end
            tick();
        end
        mem_busy = 1'b0;
        checks++; if (flush !== 1'b1 || busy !== 1'b1 || cp0_we !== 1'b0) begin
            failures++; $display("FAIL eret_drain_last flush=%0b busy=%0b we=%0b exp 1/1/0", flush, busy, cp0_we);
        end
        tick();  // COMMIT
        checks++; if (flush !== 1'b1 || cp0_we !== 1'b1 || cp0_exl_clr !== 1'b1 || cp0_exl_set !== 1'b0) begin
            failures++; $display("FAIL eret_commit flush=%0b we=%0b clr=%0b set=%0b exp 1/1/1/0", flush, cp0_we, cp0_exl_clr, cp0_exl_set);
        end
        checks++; if (cp0_epc_we !== 1'b0 || cp0_code_we !== 1'b0 || cp0_badvaddr_we !== 1'b0) begin
            failures++; $display("FAIL eret_other_we got=%0b%0b%0b exp=000", cp0_epc_we, cp0_code_we, cp0_badvaddr_we);
        end
        tick();  // REDIRECT
        if (cp0_we === 1'b1) we_pulses++;
        checks++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h8000_3000) begin
            failures++; $display("FAIL eret_redirect valid=%0b pc=%h exp 1/80003000", redirect_valid, redirect_pc);
        end
        tick();
        if (cp0_we === 1'b1) we_pulses++;
        checks++; if (we_pulses != 0 || busy !== 1'b0) begin
            failures++; $display("FAIL eret_after extra_we=%0d busy=%0b exp 0/0", we_pulses, busy);
        end
    endtask

    task automatic test_refill();
        logic [31:0] exp_pc;
`ifdef EXC_TLB_REFILL_EN
        exp_pc = 32'hBFC0_0200;
`else
        exp_pc = 32'hBFC0_0380;
`endif
        clear_inputs();
        exc_valid = 1'b1; exc_refill = 1'b1; exc_code = 5'd2; exc_pc = 32'h0040_0000;
        exc_badvaddr = 32'h0000_1234; cp0_status_bev = 1'b1;
        tick();
        clear_inputs();
        tick();
        checks++; if (cp0_code !== 5'd2 || cp0_badvaddr_we !== 1'b1 || cp0_badvaddr !== 32'h0000_1234) begin
            failures++; $display("FAIL refill_commit code=%0d bv_we=%0b bv=%h exp 2/1/00001234", cp0_code, cp0_badvaddr_we, cp0_badvaddr);
        end
        tick();
        checks++; if (redirect_pc !== exp_pc) begin
            failures++; $display("FAIL refill_redirect_pc got=%h exp=%h", redirect_pc, exp_pc);
        end
        tick();
    endtask

    task automatic test_ready_stall();
        clear_inputs();
        redirect_ready = 1'b0;
        exc_valid = 1'b1; exc_code = 5'd12; exc_pc = 32'h8000_4000;
        tick();
        clear_inputs();
        redirect_ready = 1'b0;
        tick();
        tick();  // REDIRECT, held
        for (int i = 0; i < 5; i++) begin
            checks++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h8000_0180 || cp0_we !== 1'b0) begin
                failures++; $display("FAIL stall%0d rv=%0b pc=%h we=%0b exp 1/80000180/0", i, redirect_valid, redirect_pc, cp0_we);
            end
            exc_valid  = (i % 2 == 0);
            eret_valid = (i % 2 == 1);
            exc_code   = 5'd4;
            cp0_epc    = 32'h1111_2220;
            cp0_status_bev = 1'b1;
            tick();
        end
        clear_inputs();
        checks++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h8000_0180) begin
            failures++; $display("FAIL stall_end rv=%0b pc=%h exp 1/80000180", redirect_valid, redirect_pc);
        end
        tick();  // handshake -> IDLE
        tick();
        checks++; if (busy !== 1'b0 || cp0_we !== 1'b0) begin
            failures++; $display("FAIL stall_ignored busy=%0b we=%0b exp 0/0", busy, cp0_we);
        end
    endtask

    task automatic test_both_events();
        clear_inputs();
        exc_valid = 1'b1; eret_valid = 1'b1; exc_code = 5'd10; exc_pc = 32'h8000_5000;
        cp0_epc = 32'h1234_5678;
        tick();
        clear_inputs();
        tick();
        checks++; if (cp0_exl_set !== 1'b1 || cp0_exl_clr !== 1'b0 || cp0_code !== 5'd10) begin
            failures++; $display("FAIL both_commit set=%0b clr=%0b code=%0d exp 1/0/10", cp0_exl_set, cp0_exl_clr, cp0_code);
        end
        tick();
        checks++; if (redirect_pc !== 32'h8000_0180) begin
            failures++; $display("FAIL both_redirect_pc got=%h exp=80000180", redirect_pc);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        clear_inputs();
        exc_valid = 1'b1; exc_code = 5'd9; exc_pc = 32'h8000_6000;
        tick();
        clear_inputs();
        tick();
        tick();  // REDIRECT with ready high
        eret_valid = 1'b1; cp0_epc = 32'h8000_6004;
        tick();  // cycle 4: IDLE, new event sampled at next edge
        checks++; if (busy !== 1'b0) begin
            failures++; $display("FAIL b2b_idle busy=%0b exp=0", busy);
        end
        tick();
        clear_inputs();
        checks++; if (busy !== 1'b1 || flush !== 1'b1) begin
            failures++; $display("FAIL b2b_accept busy=%0b flush=%0b exp 1/1", busy, flush);
        end
        tick();
        tick();
        checks++; if (redirect_pc !== 32'h8000_6004) begin
            failures++; $display("FAIL b2b_redirect_pc got=%h exp=80006004", redirect_pc);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        int we_seen;
        we_seen = 0;
        clear_inputs();
        exc_valid = 1'b1; exc_code = 5'd4; exc_pc = 32'h8000_7000; mem_busy = 1'b1;
        tick();  // DRAIN
        exc_valid = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        mem_busy = 1'b0;
        checks++; if (busy !== 1'b0 || flush !== 1'b0 || cp0_we !== 1'b0 || redirect_valid !== 1'b0 || redirect_pc !== 32'd0) begin
            failures++; $display("FAIL rstmid_outputs busy=%0b flush=%0b we=%0b rv=%0b pc=%h exp all 0", busy, flush, cp0_we, redirect_valid, redirect_pc);
        end
        for (int i = 0; i < 6; i++) begin
            tick();
            if (cp0_we !== 1'b0 || busy !== 1'b0) we_seen++;
        end
        checks++; if (we_seen != 0) begin
            failures++; $display("FAIL rstmid_no_we activity_cycles=%0d exp=0", we_seen);
        end
    endtask

    initial begin
        test_reset();
        test_adel();
        test_sys_delay_slot();
        test_eret_drain();
        test_refill();
        test_ready_stall();
        test_both_events();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
